// File: rtl/key_load_ctrl_if.sv
// Serial key-load handshake bundle: a restart pulse plus a bit-serial valid/ready channel.
interface key_load_ctrl_if;
  logic load_start;
  logic ser_data;
  logic ser_valid;
  logic ser_ready;

  modport master (output load_start, output ser_data, output ser_valid, input ser_ready);
  modport slave  (input load_start, input ser_data, input ser_valid, output ser_ready);
endinterface

// File: rtl/key_load_ctrl.sv
// Serial unlock-key loader: shifts in key + XOR checksum, commits the key on a match,
// holds the core stalled until a key is committed and locks out after repeated failures.
module key_load_ctrl #(
  parameter int unsigned KEY_WIDTH   = 64,
  parameter int unsigned SLICE_WIDTH = 8,
  parameter int unsigned NUM_SLICES  = 8,
  parameter int unsigned MAX_FAILS   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  key_load_ctrl_if.slave       ser,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_loaded,
  output logic                 core_stall,
  output logic                 load_err,
  output logic                 lockout
);

  localparam int unsigned FailW   = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS + 1);
  localparam logic [6:0]  KeyLast = 7'(KEY_WIDTH - 1);
  localparam logic [6:0]  SumLast = 7'(KEY_WIDTH + SLICE_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StShiftKey, StShiftSum, StCompare, StLockout} state_e;

  state_e                 state_q, state_d;
  logic [KEY_WIDTH-1:0]   shadow_q, shadow_d;
  logic [SLICE_WIDTH-1:0] sum_q, sum_d;
  logic [6:0]             bit_cnt_q, bit_cnt_d;
  logic [FailW-1:0]       fail_cnt_q, fail_cnt_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic                   key_loaded_q, key_loaded_d;
  logic                   load_err_q, load_err_d;
  logic [SLICE_WIDTH-1:0] calc_sum;

  always_comb begin
    calc_sum = '0;
    for (int i = 0; i < int'(NUM_SLICES); i++) begin
      calc_sum = calc_sum ^ shadow_q[i*SLICE_WIDTH +: SLICE_WIDTH];
    end
  end

  assign ser.ser_ready = (state_q == StShiftKey) || (state_q == StShiftSum);
  assign lockout       = (state_q == StLockout);
  assign key_out       = lockout ? '0 : key_q;
  assign key_loaded    = key_loaded_q;
  assign load_err      = load_err_q;
  // Stall for the whole of any reload so the core never observes a half-updated key.
  assign core_stall    = !key_loaded_q || (state_q != StIdle) || lockout;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    sum_d        = sum_q;
    bit_cnt_d    = bit_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    load_err_d   = load_err_q;

    unique case (state_q)
      StIdle: begin
        if (ser.load_start) begin
          state_d    = StShiftKey;
          bit_cnt_d  = '0;
          shadow_d   = '0;
          sum_d      = '0;
          load_err_d = 1'b0;
        end
      end
      StShiftKey, StShiftSum: begin
        if (ser.load_start) begin
          // Restart drops any bit offered this cycle and does not count as a failure.
          state_d   = StShiftKey;
          bit_cnt_d = '0;
          shadow_d  = '0;
          sum_d     = '0;
        end else if (ser.ser_valid) begin
          bit_cnt_d = bit_cnt_q + 7'd1;
          if (state_q == StShiftKey) begin
            shadow_d = {shadow_q[KEY_WIDTH-2:0], ser.ser_data};
            if (bit_cnt_q == KeyLast) state_d = StShiftSum;
          end else begin
            sum_d = {sum_q[SLICE_WIDTH-2:0], ser.ser_data};
            if (bit_cnt_q == SumLast) state_d = StCompare;
          end
        end
      end
      StCompare: begin
        if (calc_sum == sum_q) begin
          key_d        = shadow_q;
          key_loaded_d = 1'b1;
          fail_cnt_d   = '0;
          state_d      = StIdle;
        end else begin
          load_err_d = 1'b1;
          fail_cnt_d = fail_cnt_q + FailW'(1);
          if (fail_cnt_q == FailW'(MAX_FAILS - 1)) begin
            state_d = StLockout;
            key_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StLockout: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      sum_q        <= '0;
      bit_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      sum_q        <= sum_d;
      bit_cnt_q    <= bit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      load_err_q   <= load_err_d;
    end
  end

endmodule
